hazard_fwd_unit: RTL and testbench

Parametrised hazard-detection and operand-forwarding controller for the in-order integer pipeline, sitting between the ID/EX register and the EX operand muxes. For each of NUM_SRC source operands it selects a bypass source from NUM_FWD younger-to-older pipeline stages. It stalls on load-use hazards for a configurable LOAD_LAT cycles via an internal countdown. An optional register scoreboard tracks multi-cycle (mul/div) writebacks, with same-cycle completion forwarding.

---
 rtl/hazard_pkg.sv | 9 +
 rtl/hazard_scoreboard.sv | 30 +++
 rtl/hazard_fwd_unit.sv | 79 +++++++
 tb/tb_hazard_fwd_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared selector encodings and limits for the hazard/forwarding unit
package hazard_pkg;
  localparam int FWD_SEL_RF = 0;
  localparam int FWD_SEL_STAGE0 = 1;
  localparam int LOAD_LAT_MAX = 7;
  function automatic int fwd_sel_lop(input int num_fwd);
    return num_fwd + 1;
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: busy bits for in-flight long-latency writebacks, looked up per source operand
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] src_rs,
  input  logic                      lop_issue,
  input  logic [REG_AW-1:0]         lop_rd,
  input  logic                      lop_done,
  input  logic [REG_AW-1:0]         lop_done_rd,
  output logic [NUM_SRC-1:0]        src_busy
);
  logic [2**REG_AW-1:0] busy, busy_nxt;
  // clear on completion first so a same-cycle issue to the same rd wins; x0 never busy
  always_comb begin
    busy_nxt = busy;
    if (lop_done) busy_nxt[lop_done_rd] = 1'b0;
    if (lop_issue && lop_rd != '0) busy_nxt[lop_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  // busy register, cleared immediately by the active-low reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy <= '0;
    else busy <= busy_nxt;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lk
    assign src_busy[g] = busy[src_rs[g*REG_AW +: REG_AW]];
  end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand bypass selection plus load-use stall counter; HAZARD_SCOREBOARD_EN adds long-op scoreboard and LOP-bus forwarding
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W = $clog2(NUM_FWD + 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] src_rs,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic                      flush,
  input  logic                      lop_issue,
  input  logic [REG_AW-1:0]         lop_rd,
  input  logic                      lop_done,
  input  logic [REG_AW-1:0]         lop_done_rd,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      nop
);
  localparam logic [SEL_W-1:0] SEL_LOP = SEL_W'(fwd_sel_lop(NUM_FWD));
  localparam logic [2:0] CNT_LOAD = 3'((LOAD_LAT > LOAD_LAT_MAX ? LOAD_LAT_MAX : LOAD_LAT) - 1);
  logic [NUM_SRC-1:0][NUM_FWD-1:0] hit;
  logic [NUM_SRC-1:0][SEL_W-1:0]   sel;
  logic [NUM_SRC-1:0]              lop_hit, src_busy;
  logic [2:0]                      stall_cnt;
  logic                            detect, sb_hazard;
`ifdef HAZARD_SCOREBOARD_EN
  hazard_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) u_sb (
    .clk(clk), .rst(rst), .src_rs(src_rs), .lop_issue(lop_issue), .lop_rd(lop_rd),
    .lop_done(lop_done), .lop_done_rd(lop_done_rd), .src_busy(src_busy)
  );
  // a completing long op can feed an operand straight off its result bus
  always_comb begin
    lop_hit = '0;
    for (int i = 0; i < NUM_SRC; i++)
      lop_hit[i] = src_used[i] && lop_done && lop_done_rd != '0 && lop_done_rd == src_rs[i*REG_AW +: REG_AW];
  end
`else
  logic unused_lop;
  assign unused_lop = ^{lop_issue, lop_rd, lop_done, lop_done_rd};
  assign lop_hit = '0;
  assign src_busy = '0;
`endif
  // operand/stage match matrix and load-use detection; x0 never matches
  always_comb begin
    hit = '0;
    detect = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = 0; k < NUM_FWD; k++) begin
        hit[i][k] = src_used[i] && fwd_we[k] && fwd_rd[k*REG_AW +: REG_AW] != '0 && fwd_rd[k*REG_AW +: REG_AW] == src_rs[i*REG_AW +: REG_AW];
        detect = detect | (hit[i][k] && fwd_is_load[k]);
      end
  end
  // youngest matching stage beats the LOP bus, which beats the register file
  always_comb begin
    sel = '0;
    sb_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel[i] = lop_hit[i] ? SEL_LOP : SEL_W'(FWD_SEL_RF);
      for (int k = NUM_FWD - 1; k >= 0; k--)
        if (hit[i][k]) sel[i] = SEL_W'(FWD_SEL_STAGE0 + k);
      sb_hazard = sb_hazard | (src_used[i] && src_busy[i] && sel[i] != SEL_LOP);
    end
  end
  // load-use countdown: arm only when idle, flush aborts it
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (flush) stall_cnt <= '0;
    else if (stall_cnt != '0) stall_cnt <= stall_cnt - 3'd1;
    else if (detect) stall_cnt <= CNT_LOAD;
  assign fwd_sel = rst ? sel : '0;
  assign nop = rst && !flush && (detect || stall_cnt != '0 || sb_hazard);
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed vectors with a queued expectation scoreboard and negedge monitor
module tb_hazard_fwd_unit;
`ifdef HAZARD_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] src_rs, fwd_rd;
  logic [1:0] src_used, fwd_we, fwd_is_load;
  logic       flush, lop_issue, lop_done;
  logic [4:0] lop_rd, lop_done_rd;
  logic [3:0] fwd_sel;
  logic       nop;
  int         checks = 0;
  int         errors = 0;
  string      name_q[$];
  logic [3:0] sel_q[$];
  logic       nop_q[$];

  hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .LOAD_LAT(3)) dut (
    .clk(clk), .rst(rst), .src_rs(src_rs), .src_used(src_used), .fwd_rd(fwd_rd),
    .fwd_we(fwd_we), .fwd_is_load(fwd_is_load), .flush(flush), .lop_issue(lop_issue),
    .lop_rd(lop_rd), .lop_done(lop_done), .lop_done_rd(lop_done_rd), .fwd_sel(fwd_sel), .nop(nop)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (name_q.size() > 0) begin
      string      n;
      logic [3:0] s;
      logic       p;
      n = name_q.pop_front();
      s = sel_q.pop_front();
      p = nop_q.pop_front();
      checks++;
      if (fwd_sel !== s || nop !== p) begin
        errors++;
        $display("FAIL %s: fwd_sel=%b nop=%b, expected fwd_sel=%b nop=%b", n, fwd_sel, nop, s, p);
      end
    end

  task automatic clr();
    src_rs = '0; src_used = '0; fwd_rd = '0; fwd_we = '0; fwd_is_load = '0;
    flush = 1'b0; lop_issue = 1'b0; lop_rd = '0; lop_done = 1'b0; lop_done_rd = '0;
  endtask

  task automatic chk(input string n, input logic [3:0] s, input logic p);
    name_q.push_back(n);
    sel_q.push_back(s);
    nop_q.push_back(p);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    @(posedge clk);
    #1;
    src_rs = {5'd0, 5'd5}; src_used = 2'b01; fwd_rd = {5'd0, 5'd5}; fwd_we = 2'b01; fwd_is_load = 2'b01;
    chk("reset_forced_zero", 4'b0000, 1'b0);
    rst = 1'b1; clr();
    chk("idle_after_reset", 4'b0000, 1'b0);
    src_rs = {5'd5, 5'd5}; src_used = 2'b01; fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11;
    chk("youngest_wins_unused_op1", 4'b0001, 1'b0);
    src_used = 2'b11;
    chk("both_ops_stage0", 4'b0101, 1'b0);
    src_rs = {5'd7, 5'd0}; fwd_rd = {5'd7, 5'd0};
    chk("x0_rf_memwb_only", 4'b1000, 1'b0);
    fwd_we = 2'b01;
    chk("no_we_no_fwd", 4'b0000, 1'b0);
    clr(); src_rs = {5'd9, 5'd3}; src_used = 2'b11; fwd_rd = {5'd0, 5'd9}; fwd_we = 2'b01; fwd_is_load = 2'b01;
    chk("load_use_c1", 4'b0100, 1'b1);
    chk("load_use_c2", 4'b0100, 1'b1);
    chk("load_use_c3", 4'b0100, 1'b1);
    fwd_rd = {5'd9, 5'd0}; fwd_we = 2'b10; fwd_is_load = 2'b00;
    chk("load_use_released", 4'b1000, 1'b0);
    clr(); src_rs = {5'd9, 5'd3}; src_used = 2'b11; fwd_rd = {5'd0, 5'd9}; fwd_we = 2'b01; fwd_is_load = 2'b01;
    chk("flush_stall_c1", 4'b0100, 1'b1);
    flush = 1'b1;
    chk("flush_kills_nop", 4'b0100, 1'b0);
    flush = 1'b0; fwd_is_load = 2'b00;
    chk("flush_cleared_cnt", 4'b0100, 1'b0);
    clr(); src_rs = {5'd0, 5'd0}; src_used = 2'b01; fwd_we = 2'b01; fwd_is_load = 2'b01;
    chk("load_x0_no_stall", 4'b0000, 1'b0);
    clr(); lop_issue = 1'b1; lop_rd = 5'd12;
    chk("lop_issue_cycle", 4'b0000, 1'b0);
    clr(); src_rs = {5'd0, 5'd12}; src_used = 2'b01;
    chk("lop_busy_stall1", 4'b0000, SB);
    chk("lop_busy_stall2", 4'b0000, SB);
    lop_done = 1'b1; lop_done_rd = 5'd12;
    chk("lop_done_forward", SB ? 4'b0011 : 4'b0000, 1'b0);
    lop_done = 1'b0;
    chk("lop_busy_cleared", 4'b0000, 1'b0);
    clr(); lop_issue = 1'b1; lop_rd = 5'd4; lop_done = 1'b1; lop_done_rd = 5'd4;
    chk("issue_done_same_rd", 4'b0000, 1'b0);
    clr(); src_rs = {5'd0, 5'd4}; src_used = 2'b01;
    chk("set_wins_busy4", 4'b0000, SB);
    lop_done = 1'b1; lop_done_rd = 5'd4;
    chk("busy4_done_forward", SB ? 4'b0011 : 4'b0000, 1'b0);
    clr(); lop_issue = 1'b1; lop_rd = 5'd0;
    chk("issue_x0", 4'b0000, 1'b0);
    clr(); src_used = 2'b01; lop_done = 1'b1; lop_done_rd = 5'd0;
    chk("x0_no_stall_no_lop_fwd", 4'b0000, 1'b0);
    clr(); src_rs = {5'd0, 5'd6}; src_used = 2'b01; fwd_rd = {5'd6, 5'd0}; fwd_we = 2'b10; lop_done = 1'b1; lop_done_rd = 5'd6;
    chk("stage_beats_lop", 4'b0010, 1'b0);
    clr(); lop_issue = 1'b1; lop_rd = 5'd12; src_rs = {5'd9, 5'd0}; src_used = 2'b10; fwd_rd = {5'd0, 5'd9}; fwd_we = 2'b01; fwd_is_load = 2'b01;
    chk("mid_stall_c1", 4'b0100, 1'b1);
    lop_issue = 1'b0; src_rs = {5'd9, 5'd12}; src_used = 2'b11;
    chk("mid_stall_c2", 4'b0100, 1'b1);
    rst = 1'b0;
    chk("reset_mid_stall", 4'b0000, 1'b0);
    rst = 1'b1; clr(); src_rs = {5'd0, 5'd12}; src_used = 2'b01;
    chk("reset_cleared_state", 4'b0000, 1'b0);
    clr();
    chk("final_idle", 4'b0000, 1'b0);
    if (name_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", name_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
